// File: rtl/msp430_pkg.sv
// rtl/msp430_pkg.sv - shared mode and state encodings for the effective-address calculator.
package msp430_pkg;

   typedef enum logic [1:0] {
      MODE_INDEXED  = 2'd0,
      MODE_SYMBOLIC = 2'd1,
      MODE_ABSOLUTE = 2'd2,
      MODE_RESERVED = 2'd3
   } addr_mode_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_ADD   = 2'd2,
      S_DONE  = 2'd3
   } calc_state_e;

endpackage

// File: rtl/addr_calc.sv
// rtl/addr_calc.sv - effective-address calculator: fetches the extension word, adds
// it to Rn / PC / zero, and holds the result until the consumer clears it.
module addr_calc
   import msp430_pkg::*;
#(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        CALC_start,
   input  logic [1:0]  mode,
   input  logic        BW,
   input  logic [15:0] reg_base_in,
   input  logic [15:0] reg_PC_out,
   input  logic [15:0] MDB_out,
   input  logic        MDB_valid,
   input  logic        CALC_clear,
   output logic        ext_req,
   output logic        PC_inc,
   output logic [15:0] CALC_out,
   output logic        CALC_done,
   output logic        calc_err
);

   calc_state_e       state_q, state_d;
   addr_mode_e        mode_q, mode_d;
   logic              bw_q, bw_d;
   logic [15:0]       base_q, base_d;
   logic [15:0]       pc_q, pc_d;
   logic [15:0]       offset_q, offset_d;
   logic [15:0]       calc_out_q, calc_out_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              calc_err_q, calc_err_d;
   logic [15:0]       ea;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mode_q     <= MODE_INDEXED;
         bw_q       <= 1'b0;
         base_q     <= 16'h0000;
         pc_q       <= 16'h0000;
         offset_q   <= 16'h0000;
         calc_out_q <= 16'h0000;
         cnt_q      <= '0;
         calc_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         bw_q       <= bw_d;
         base_q     <= base_d;
         pc_q       <= pc_d;
         offset_q   <= offset_d;
         calc_out_q <= calc_out_d;
         cnt_q      <= cnt_d;
         calc_err_q <= calc_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      bw_d       = bw_q;
      base_d     = base_q;
      pc_d       = pc_q;
      offset_d   = offset_q;
      calc_out_d = calc_out_q;
      cnt_d      = cnt_q;
      calc_err_d = 1'b0;
      ea         = offset_q;

      case (mode_q)
         MODE_INDEXED:  ea = base_q + offset_q;
         MODE_SYMBOLIC: ea = pc_q + offset_q;
         default:       ea = offset_q;
      endcase
      // Word accesses are always even-aligned.
      if (!bw_q) ea[0] = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (CALC_start) begin
               if (addr_mode_e'(mode) == MODE_RESERVED) begin
                  calc_err_d = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  mode_d  = addr_mode_e'(mode);
                  bw_d    = BW;
                  base_d  = reg_base_in;
                  pc_d    = reg_PC_out;
                  cnt_d   = '0;
                  state_d = S_FETCH;
               end
            end else if (state_q == S_DONE && CALC_clear) begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            // A word arriving on the last allowed cycle still counts.
            if (MDB_valid) begin
               offset_d = MDB_out;
               state_d  = S_ADD;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               calc_err_d = 1'b1;
               cnt_d      = '0;
               state_d    = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_ADD: begin
            calc_out_d = ea;
            state_d    = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ext_req   = (state_q == S_FETCH);
   assign PC_inc    = (state_q == S_FETCH) && MDB_valid;
   assign CALC_done = (state_q == S_DONE);
   assign CALC_out  = calc_out_q;
   assign calc_err  = calc_err_q;

endmodule

// File: doc/addr_calc.md
ADDR_CALC -- requirements
Module: addr_calc

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max cycles waiting for MDB_valid in FETCH.
REQ-002 SHALL have parameter CNT_W, default 4, width of timeout counter.
REQ-003 clk  input  1  single clock, all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 CALC_start  input  1  one-cycle request to begin an effective-address calculation.
REQ-006 mode  input  2  0 indexed X(Rn), 1 symbolic (PC-relative), 2 absolute &ADDR, 3 reserved.
REQ-007 BW  input  1  1 = byte access, 0 = word access.
REQ-008 reg_base_in  input  16  Rn contents, sampled on accepted CALC_start.
REQ-009 reg_PC_out  input  16  PC (address of extension word), sampled on accepted CALC_start.
REQ-010 MDB_out  input  16  memory data bus; extension word when MDB_valid=1.
REQ-011 MDB_valid  input  1  extension word present on MDB_out this cycle.
REQ-012 CALC_clear  input  1  consumer acknowledges result; releases CALC_done.
REQ-013 ext_req  output  1  extension-word fetch request (PC on MAB).
REQ-014 PC_inc  output  1  one-cycle pulse: advance PC by 2 past extension word.
REQ-015 CALC_out  output  16  effective address; feeds MAB address mux.
REQ-016 CALC_done  output  1  CALC_out valid; held until cleared.
REQ-017 calc_err  output  1  one-cycle pulse on timeout or reserved mode.

Function
REQ-018 SHALL implement states IDLE, FETCH, ADD, DONE.
REQ-019 IDLE: CALC_start=1 with mode 0-2 SHALL latch mode, BW, reg_base_in, reg_PC_out and enter FETCH next cycle.
REQ-020 IDLE: CALC_start=1 with mode=3 SHALL pulse calc_err next cycle and remain IDLE.
REQ-021 FETCH: ext_req SHALL be 1; counter increments each cycle without MDB_valid.
REQ-022 FETCH with MDB_valid=1 SHALL latch MDB_out as offset, pulse PC_inc same cycle, enter ADD.
REQ-023 FETCH with counter reaching TIMEOUT and no MDB_valid SHALL pulse calc_err, clear ext_req, return IDLE.
REQ-024 MDB_valid and timeout in same cycle: MDB_valid SHALL win.
REQ-025 ADD SHALL compute: mode0 base+offset, mode1 PC_latched+offset, mode2 offset; sum modulo 2^16, carry discarded.
REQ-026 Word access (BW=0) SHALL force CALC_out[0]=0; byte access SHALL pass bit 0 unchanged.
REQ-027 ADD SHALL register CALC_out and enter DONE; CALC_done rises 1 cycle after ADD (latency start->done = 3 cycles + MDB wait).
REQ-028 DONE: CALC_out and CALC_done SHALL hold until CALC_clear=1, then return IDLE with CALC_done=0 next cycle.
REQ-029 DONE: CALC_start=1 (with or without CALC_clear) SHALL begin a new calculation (start wins), CALC_done falling next cycle.
REQ-030 CALC_start in FETCH or ADD SHALL be ignored.
REQ-031 MDB_valid outside FETCH SHALL be ignored.
REQ-032 CALC_out SHALL retain its last value in IDLE; only ADD updates it.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, counter 0, CALC_out 16'h0000, CALC_done/ext_req/PC_inc/calc_err 0, regardless of state.
REQ-034 Reset deasserted mid-operation SHALL not resume any prior calculation.

Structure
REQ-035 Mode encodings and state encodings SHALL live in shared package msp430_pkg.
REQ-036 Single module; adder and bit-0 masking inline, no sub-module.

Verification
REQ-037 mode0, base=16'h0200, MDB_out=16'h0010 after 2 cycles, BW=0 -> PC_inc once, CALC_out=16'h0210, CALC_done held until CALC_clear.
REQ-038 mode1, PC=16'hC002, offset=16'hFFFE -> CALC_out=16'hC000 (wrap); mode2, offset=16'h0123, BW=0 -> 16'h0122; BW=1 -> 16'h0123.
REQ-039 mode0, no MDB_valid for 15 cycles -> calc_err pulse, ext_req low, IDLE, CALC_done stays 0.
REQ-040 DONE with CALC_start and CALC_clear same cycle -> new FETCH entered, CALC_done low next cycle.
REQ-041 rst_n low during FETCH -> outputs zero asynchronously; later MDB_valid ignored, no PC_inc.
REQ-042 mode=3 start -> calc_err pulse, no ext_req, state IDLE.
